// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int unsigned mem_depth(input int unsigned ins_address);
    return 32'd1 << (ins_address - 2);
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader word stream: valid/ready handshake with an end-of-image marker.
interface imem_boot_ctrl_if #(
  parameter int INS_W = 32
) ();
  logic             ld_valid;
  logic             ld_ready;
  logic [INS_W-1:0] ld_data;
  logic             ld_last;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/imem_boot_ctrl.sv
// Owns the instruction memory: loads a boot image word by word, then
// serves core fetches combinationally from the memory read port.
module imem_boot_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter logic [INS_W-1:0] NOP_INSTR   = imem_ctrl_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   boot_req,
  imem_boot_ctrl_if.slave        ld,
  input  logic [INS_ADDRESS-1:0] cpu_addr,
  output logic [INS_W-1:0]       cpu_instr,
  output logic                   cpu_stall,
  output logic                   misalign,
  output logic                   mem_we,
  output logic [INS_ADDRESS-1:0] mem_wa,
  output logic [INS_W-1:0]       mem_wd,
  output logic [INS_ADDRESS-1:0] mem_ra,
  input  logic [INS_W-1:0]       mem_rd,
  output logic [INS_ADDRESS-2:0] word_count,
  output logic                   load_err
);

  localparam int          AW       = INS_ADDRESS - 2;
  localparam int          WCW      = INS_ADDRESS - 1;
  localparam int unsigned DEPTH    = mem_depth(INS_ADDRESS);
  localparam logic [AW-1:0] WPTR_MAX = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [WCW-1:0]  wc_q, wc_d;
  logic            err_q, err_d;
  logic            fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      wptr_q  <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
    end
  end

  // boot_req masks ld_ready so a coincident word is never half-accepted.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    wc_d        = wc_q;
    err_d       = err_q;
    ld.ld_ready = (state_q == LOAD) && !boot_req;
    fire        = ld.ld_ready && ld.ld_valid;
    mem_we      = fire;
    mem_wa      = {wptr_q, 2'b00};
    mem_wd      = ld.ld_data;
    mem_ra      = {wptr_q, 2'b00};
    cpu_instr   = NOP_INSTR;
    cpu_stall   = 1'b1;
    misalign    = 1'b0;

    if (state_q == RUN) begin
      mem_ra    = cpu_addr;
      cpu_instr = mem_rd;
      cpu_stall = 1'b0;
      misalign  = |cpu_addr[1:0];
    end

    if (boot_req) begin
      state_d = LOAD;
      wptr_d  = '0;
      wc_d    = '0;
      err_d   = 1'b0;
    end else if (fire) begin
      wc_d   = WCW'(wptr_q) + WCW'(1);
      wptr_d = wptr_q + AW'(1);
      if (ld.ld_last) begin
        state_d = RUN;
        wptr_d  = '0;
      end else if (wptr_q == WPTR_MAX) begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    end
  end

  assign word_count = wc_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a behavioural 128-word memory.
module tb_imem_boot_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        boot_req;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        misalign;
  logic        mem_we;
  logic [8:0]  mem_wa;
  logic [31:0] mem_wd;
  logic [8:0]  mem_ra;
  logic [31:0] mem_rd;
  logic [7:0]  word_count;
  logic        load_err;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mem [0:127];

  imem_boot_ctrl_if #(.INS_W(32)) ld_bus ();

  imem_boot_ctrl #(
    .INS_ADDRESS (9),
    .INS_W       (32),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .boot_req   (boot_req),
    .ld         (ld_bus.slave),
    .cpu_addr   (cpu_addr),
    .cpu_instr  (cpu_instr),
    .cpu_stall  (cpu_stall),
    .misalign   (misalign),
    .mem_we     (mem_we),
    .mem_wa     (mem_wa),
    .mem_wd     (mem_wd),
    .mem_ra     (mem_ra),
    .mem_rd     (mem_rd),
    .word_count (word_count),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_wa[8:2]] <= mem_wd;
  assign mem_rd = mem[mem_ra[8:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    ld_bus.ld_valid = v;
    ld_bus.ld_data  = d;
    ld_bus.ld_last  = l;
  endtask

  task automatic pulse_boot();
    drive(1'b0, '0, 1'b0);
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; boot_req = 1'b0; cpu_addr = '0;
    drive(1'b0, '0, 1'b0);
    step(); step();
    reset = 1'b0;
    #1;
    vectors++;
    if (ld_bus.ld_ready !== 1'b1 || cpu_stall !== 1'b1 || cpu_instr !== NOP) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b stall=%b instr=%h want 1 1 %h",
               ld_bus.ld_ready, cpu_stall, cpu_instr, NOP);
    end
    vectors++;
    if (word_count !== 8'd0 || load_err !== 1'b0 || mem_we !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: wc=%0d err=%b we=%b mis=%b want 0 0 0 0",
               word_count, load_err, mem_we, misalign);
    end
  endtask

  task automatic test_basic_load();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA0 + i, i == 2);
      #1;
      vectors++;
      if (mem_we !== 1'b1 || mem_wa !== 9'(i * 4) || mem_wd !== 32'hA0 + i) begin
        errors++;
        $display("FAIL basic_write%0d: we=%b wa=%h wd=%h want 1 %h %h",
                 i, mem_we, mem_wa, mem_wd, 9'(i * 4), 32'hA0 + i);
      end
      step();
    end
    drive(1'b0, '0, 1'b0);
    cpu_addr = 9'h008;
    #1;
    vectors++;
    if (cpu_stall !== 1'b0 || word_count !== 8'd3 || ld_bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_run: stall=%b wc=%0d ready=%b want 0 3 0",
               cpu_stall, word_count, ld_bus.ld_ready);
    end
    vectors++;
    if (cpu_instr !== 32'hA2 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL basic_fetch: instr=%h mis=%b want 000000a2 0", cpu_instr, misalign);
    end
    // ld_valid in RUN must be ignored
    drive(1'b1, 32'hDEAD, 1'b0);
    #1;
    vectors++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL run_ignores_valid: we=%b want 0", mem_we);
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_valid_toggle();
    logic        v_pat [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] d_pat [3] = '{32'hB0, 32'hBAD, 32'hB1};
    logic [8:0]  a_pat [3] = '{9'h000, 9'h004, 9'h004};
    pulse_boot();
    for (int i = 0; i < 3; i++) begin
      drive(v_pat[i], d_pat[i], i == 2);
      #1;
      vectors++;
      if (mem_we !== v_pat[i] || mem_wa !== a_pat[i] || cpu_stall !== 1'b1 || cpu_instr !== NOP) begin
        errors++;
        $display("FAIL toggle%0d: we=%b wa=%h stall=%b instr=%h want %b %h 1 %h",
                 i, mem_we, mem_wa, cpu_stall, cpu_instr, v_pat[i], a_pat[i], NOP);
      end
      step();
    end
    drive(1'b0, '0, 1'b0);
    cpu_addr = 9'h004;
    #1;
    vectors++;
    if (word_count !== 8'd2 || cpu_stall !== 1'b0 || cpu_instr !== 32'hB1) begin
      errors++;
      $display("FAIL toggle_result: wc=%0d stall=%b instr=%h want 2 0 000000b1",
               word_count, cpu_stall, cpu_instr);
    end
  endtask

  task automatic test_overflow();
    pulse_boot();
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 32'hC000_0000 + i, 1'b0);
      #1;
      if (i == 127) begin
        vectors++;
        if (mem_we !== 1'b1 || mem_wa !== 9'h1FC) begin
          errors++;
          $display("FAIL ovf_last_write: we=%b wa=%h want 1 1fc", mem_we, mem_wa);
        end
      end
      step();
    end
    #1;
    vectors++;
    if (load_err !== 1'b1 || ld_bus.ld_ready !== 1'b0 || cpu_stall !== 1'b1 ||
        word_count !== 8'd128 || mem_we !== 1'b0 || cpu_instr !== NOP) begin
      errors++;
      $display("FAIL ovf_err_state: err=%b ready=%b stall=%b wc=%0d we=%b instr=%h want 1 0 1 128 0 %h",
               load_err, ld_bus.ld_ready, cpu_stall, word_count, mem_we, cpu_instr, NOP);
    end
    step();
    vectors++;
    if (load_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: err=%b want 1", load_err);
    end
    drive(1'b0, '0, 1'b0);
    pulse_boot();
    vectors++;
    if (load_err !== 1'b0 || ld_bus.ld_ready !== 1'b1 || word_count !== 8'd0) begin
      errors++;
      $display("FAIL ovf_reboot: err=%b ready=%b wc=%0d want 0 1 0",
               load_err, ld_bus.ld_ready, word_count);
    end
  endtask

  task automatic test_full_last();
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 32'hD000_0000 + i, i == 127);
      step();
    end
    drive(1'b0, '0, 1'b0);
    cpu_addr = 9'h1FC;
    #1;
    vectors++;
    if (load_err !== 1'b0 || cpu_stall !== 1'b0 || word_count !== 8'd128) begin
      errors++;
      $display("FAIL full_last: err=%b stall=%b wc=%0d want 0 0 128",
               load_err, cpu_stall, word_count);
    end
    vectors++;
    if (cpu_instr !== 32'hD000_007F) begin
      errors++;
      $display("FAIL full_fetch_top: instr=%h want d000007f", cpu_instr);
    end
  endtask

  task automatic test_misalign();
    cpu_addr = 9'h006;
    #1;
    vectors++;
    if (misalign !== 1'b1 || cpu_instr !== 32'hD000_0001) begin
      errors++;
      $display("FAIL misalign_6: mis=%b instr=%h want 1 d0000001", misalign, cpu_instr);
    end
    cpu_addr = 9'h004;
    #1;
    vectors++;
    if (misalign !== 1'b0 || cpu_instr !== 32'hD000_0001) begin
      errors++;
      $display("FAIL misalign_4: mis=%b instr=%h want 0 d0000001", misalign, cpu_instr);
    end
  endtask

  task automatic test_boot_collision();
    pulse_boot();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hE0 + i, 1'b0);
      step();
    end
    drive(1'b1, 32'hE5, 1'b0);
    boot_req = 1'b1;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || ld_bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL collide_block: we=%b ready=%b want 0 0", mem_we, ld_bus.ld_ready);
    end
    step();
    boot_req = 1'b0;
    drive(1'b1, 32'hE9, 1'b1);
    #1;
    vectors++;
    if (word_count !== 8'd0 || mem_wa !== 9'h000 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL collide_restart: wc=%0d wa=%h we=%b want 0 000 1",
               word_count, mem_wa, mem_we);
    end
    step();
    drive(1'b0, '0, 1'b0);
    cpu_addr = 9'h000;
    #1;
    vectors++;
    if (cpu_instr !== 32'hE9 || word_count !== 8'd1) begin
      errors++;
      $display("FAIL collide_fetch: instr=%h wc=%0d want 000000e9 1", cpu_instr, word_count);
    end
  endtask

  task automatic test_reset_midload();
    pulse_boot();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hF0 + i, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    #1;
    vectors++;
    if (word_count !== 8'd2) begin
      errors++;
      $display("FAIL midload_count: wc=%0d want 2", word_count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 32'hF7, 1'b1);
    #1;
    vectors++;
    if (word_count !== 8'd0 || ld_bus.ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_wa !== 9'h000) begin
      errors++;
      $display("FAIL midload_reset: wc=%0d ready=%b we=%b wa=%h want 0 1 1 000",
               word_count, ld_bus.ld_ready, mem_we, mem_wa);
    end
    step();
    drive(1'b0, '0, 1'b0);
    cpu_addr = 9'h000;
    #1;
    vectors++;
    if (cpu_stall !== 1'b0 || cpu_instr !== 32'hF7 || word_count !== 8'd1) begin
      errors++;
      $display("FAIL midload_fetch: stall=%b instr=%h wc=%0d want 0 000000f7 1",
               cpu_stall, cpu_instr, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_valid_toggle();
    test_overflow();
    test_full_last();
    test_misalign();
    test_boot_collision();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Controller that owns the instruction memory's two access paths: boot-time loading of program words and run-time fetch by the core.
- Accepts a stream of 32-bit words over a valid/ready handshake and sequences them into consecutive word addresses of the instruction memory's write port.
- Holds the core stalled and feeds it NOPs until loading completes, then passes core fetches through to the memory read port.
- Sits between the boot/debug loader, the core's PC/fetch stage and the instruction memory.

Parameters:
INS_ADDRESS, 9, byte-address width; memory depth is 2**(INS_ADDRESS-2) words
INS_W, 32, instruction/data word width
NOP_INSTR, 32'h00000013, instruction returned to the core while stalled (addi x0,x0,0)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
boot_req  input  1  single-cycle pulse; restarts loading from word 0
ld_valid  input  1  loader word valid
ld_ready  output  1  controller accepts a word this cycle
ld_data  input  INS_W  loader word
ld_last  input  1  qualifies the final word of the image
cpu_addr  input  INS_ADDRESS  core fetch byte address (PC)
cpu_instr  output  INS_W  instruction returned to the core
cpu_stall  output  1  core must hold PC
misalign  output  1  cpu_addr[1:0]!=0 while in RUN
mem_we  output  1  instruction memory write enable
mem_wa  output  INS_ADDRESS  write byte address, always word-aligned
mem_wd  output  INS_W  write data
mem_ra  output  INS_ADDRESS  read byte address
mem_rd  input  INS_W  read data (combinational from mem_ra)
word_count  output  INS_ADDRESS-1  words written by the last load (0..2**(INS_ADDRESS-2))
load_err  output  1  image overflowed memory

Behaviour:
- States: LOAD, RUN, ERR. Register state, wptr (INS_ADDRESS-2 bits), word_count, load_err.
- Reset, applied at a clk edge: state=LOAD, wptr=0, word_count=0, load_err=0.
- Reset mid-load: abandons the load; memory contents are undefined but are not cleared.
- LOAD state:
  - ld_ready=1, cpu_stall=1, cpu_instr=NOP_INSTR, misalign=0.
  - Handshake fires when ld_valid & ld_ready. In that same cycle, combinationally: mem_we=1, mem_wa={wptr,2'b00}, mem_wd=ld_data. mem_we=0 otherwise.
  - On each fire, at the next edge: wptr<=wptr+1 and word_count<=wptr+1.
  - Fire with ld_last=1 -> next state RUN; wptr resets to 0.
  - Fire at wptr==2**(INS_ADDRESS-2)-1 with ld_last=0 -> the word is written, word_count=max, next state ERR, load_err<=1.
  - Fire at the max address with ld_last=1 -> RUN; this is legal and no error.
  - ld_valid low stalls indefinitely; no timeout.
- RUN state:
  - ld_ready=0, mem_we=0, cpu_stall=0.
  - mem_ra=cpu_addr, cpu_instr=mem_rd, giving zero-cycle fetch latency.
  - misalign=|cpu_addr[1:0]; data is still returned from the word-aligned address.
  - ld_valid is ignored.
- ERR state:
  - ld_ready=0, cpu_stall=1, cpu_instr=NOP_INSTR, load_err=1 (sticky).
- boot_req, in any state, takes priority over any handshake in the same cycle:
  - The concurrent word is not accepted; ld_ready is forced to 0 that cycle.
  - Next state is LOAD with wptr=0, word_count=0, load_err=0.
- Outside RUN, mem_ra is driven with {wptr,2'b00}; the value is don't-care but must not be X.
- load_err is cleared only by reset or boot_req.
- All outputs are fully determined every cycle; there are no latches.

Decomposition:
- Package imem_ctrl_pkg holds:
  - enum state_t {LOAD, RUN, ERR}
  - constant NOP_INSTR
  - localparam function for depth: 2**(INS_ADDRESS-2)
- No sub-module. The design is a single FSM plus counter in one module.
- The instruction memory stays external and is connected via the mem_* ports.

Test Plan:
- Reset, then stream 3 words 0xA0,0xA1,0xA2 (ld_last on 3rd) with ld_valid held high -> mem_we pulses at mem_wa 0x000/0x004/0x008. After the 3rd edge: state RUN, cpu_stall=0, word_count=3. cpu_addr=0x008 -> cpu_instr=0xA2.
- During LOAD, ld_valid toggles 1,0,1 -> exactly 2 writes, no address skipped; cpu_instr=0x00000013 and cpu_stall=1 throughout.
- Stream 128 words without ld_last -> 128th word written at 0x1FC, then load_err=1, ld_ready=0, cpu_stall=1, word_count=128. A following boot_req -> LOAD, load_err=0.
- 128 words with ld_last on the 128th -> RUN, load_err=0, word_count=128.
- In RUN, cpu_addr=0x006 -> misalign=1 and cpu_instr equals the word at 0x004.
- boot_req asserted together with a valid handshake on word 5 -> no write that cycle, wptr=0. Reset asserted mid-load after 2 words -> LOAD, word_count=0, first new word written at 0x000.
